// File: rtl/blast_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// blast_mem_arbiter_if
// Bundles the two requester ports (host H, Blast engine E) and the on-chip
// memory port that blast_mem_arbiter sits between.
//   h_* / e_*   : request, lock, write, address, writedata, byteenable in;
//                 gnt and readdatavalid back to the requester
//   readdata    : memory_readdata forwarded to both requesters
//   memory_*    : address/write/writedata/byteenable/chipselect/clken out,
//                 readdata in
// Modports:
//   slave  - the arbiter's view (requester signals in, grants/memory out)
//   master - the environment's view (requesters and memory model)
// ----------------------------------------------------------------------------
interface blast_mem_arbiter_if #(
    parameter int MEMORY_DATAWIDTH = 64,
    parameter int MEMORY_ADDRESS   = 14
);
    localparam int BW = MEMORY_DATAWIDTH / 8;

    logic                        h_req;
    logic                        h_lock;
    logic                        h_write;
    logic [MEMORY_ADDRESS-1:0]   h_address;
    logic [MEMORY_DATAWIDTH-1:0] h_writedata;
    logic [BW-1:0]               h_byteenable;
    logic                        h_gnt;
    logic                        h_readdatavalid;

    logic                        e_req;
    logic                        e_lock;
    logic                        e_write;
    logic [MEMORY_ADDRESS-1:0]   e_address;
    logic [MEMORY_DATAWIDTH-1:0] e_writedata;
    logic [BW-1:0]               e_byteenable;
    logic                        e_gnt;
    logic                        e_readdatavalid;

    logic [MEMORY_DATAWIDTH-1:0] readdata;

    logic [MEMORY_ADDRESS-1:0]   memory_address;
    logic                        memory_write;
    logic [MEMORY_DATAWIDTH-1:0] memory_writedata;
    logic [BW-1:0]               memory_byteenable;
    logic                        memory_chipselect;
    logic                        memory_clken;
    logic [MEMORY_DATAWIDTH-1:0] memory_readdata;

    modport slave (
        input  h_req, h_lock, h_write, h_address, h_writedata, h_byteenable,
        input  e_req, e_lock, e_write, e_address, e_writedata, e_byteenable,
        input  memory_readdata,
        output h_gnt, h_readdatavalid, e_gnt, e_readdatavalid, readdata,
        output memory_address, memory_write, memory_writedata,
        output memory_byteenable, memory_chipselect, memory_clken
    );

    modport master (
        output h_req, h_lock, h_write, h_address, h_writedata, h_byteenable,
        output e_req, e_lock, e_write, e_address, e_writedata, e_byteenable,
        output memory_readdata,
        input  h_gnt, h_readdatavalid, e_gnt, e_readdatavalid, readdata,
        input  memory_address, memory_write, memory_writedata,
        input  memory_byteenable, memory_chipselect, memory_clken
    );
endinterface

// File: rtl/blast_mem_arbiter.sv
// ----------------------------------------------------------------------------
// blast_mem_arbiter
// Shares the single on-chip memory port between the host (H) and the Blast
// engine (E). Round-robin arbitration with burst locking (a lock is forcibly
// released after MAX_BURST consecutive beats when the other side waits).
// Read data returns tagged to the issuing requester READ_LATENCY cycles
// after the grant cycle.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   bus           - blast_mem_arbiter_if.slave (requester + memory signals)
// Optional feature (macro BLAST_ARB_STATS_EN):
//   stats_clear    in   synchronous clear of the counters below
//   h_grant_count  out  granted host beats, saturating
//   e_grant_count  out  granted engine beats, saturating
//   conflict_count out  cycles with both requests, saturating
//
// Lock-owner state:
//   state    | meaning
//   OWN_NONE | no burst lock held; plain round-robin
//   OWN_H    | host holds the lock, burst_cnt counts its locked beats
//   OWN_E    | engine holds the lock, burst_cnt counts its locked beats
// ----------------------------------------------------------------------------
module blast_mem_arbiter #(
    parameter int MEMORY_DATAWIDTH = 64,
    parameter int MEMORY_ADDRESS   = 14,
    parameter int READ_LATENCY     = 1,
    parameter int MAX_BURST        = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    blast_mem_arbiter_if.slave bus
`ifdef BLAST_ARB_STATS_EN
    ,
    input  logic               stats_clear,
    output logic [31:0]        h_grant_count,
    output logic [31:0]        e_grant_count,
    output logic [15:0]        conflict_count
`endif
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam int BW = MEMORY_DATAWIDTH / 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_H    = 2'd1,
        OWN_E    = 2'd2
    } owner_t;

    owner_t                      lock_owner, lock_owner_nxt, win_id;
    logic [CW-1:0]               burst_cnt, burst_cnt_nxt;
    logic                        last_winner, last_winner_nxt;
    logic                        gnt_h, gnt_e, any_gnt, burst_open;
    logic                        win_write, win_lock;
    logic [MEMORY_ADDRESS-1:0]   win_address;
    logic [MEMORY_DATAWIDTH-1:0] win_wdata, wdata_q;
    logic [BW-1:0]               win_be;
    logic [READ_LATENCY-1:0]     rd_valid, rd_id;

    // Grant selection: an unexpired lock wins, otherwise a lone requester,
    // otherwise whoever did not win last. When the lock has run MAX_BURST
    // beats the owner is also last_winner, so the tie-break hands the slot
    // to the waiting side.
    always_comb begin
        gnt_h      = 1'b0;
        gnt_e      = 1'b0;
        burst_open = (burst_cnt < CW'(MAX_BURST));
        if (lock_owner == OWN_H && bus.h_req && burst_open) begin
            gnt_h = 1'b1;
        end else if (lock_owner == OWN_E && bus.e_req && burst_open) begin
            gnt_e = 1'b1;
        end else if (bus.h_req && bus.e_req) begin
            gnt_h = last_winner;
            gnt_e = ~last_winner;
        end else begin
            gnt_h = bus.h_req;
            gnt_e = bus.e_req;
        end
    end

    // Winner mux towards memory; idle cycles keep the last writedata.
    always_comb begin
        any_gnt     = gnt_h | gnt_e;
        win_id      = OWN_NONE;
        win_write   = 1'b0;
        win_lock    = 1'b0;
        win_address = '0;
        win_wdata   = wdata_q;
        win_be      = '0;
        if (gnt_h) begin
            win_id      = OWN_H;
            win_write   = bus.h_write;
            win_lock    = bus.h_lock;
            win_address = bus.h_address;
            win_wdata   = bus.h_writedata;
            win_be      = bus.h_byteenable;
        end else if (gnt_e) begin
            win_id      = OWN_E;
            win_write   = bus.e_write;
            win_lock    = bus.e_lock;
            win_address = bus.e_address;
            win_wdata   = bus.e_writedata;
            win_be      = bus.e_byteenable;
        end
    end

    always_comb begin
        lock_owner_nxt  = lock_owner;
        burst_cnt_nxt   = burst_cnt;
        last_winner_nxt = last_winner;
        if (any_gnt) begin
            last_winner_nxt = gnt_e;
            if (win_lock) begin
                lock_owner_nxt = win_id;
                // A continuing, unexpired lock keeps counting; a new lock or
                // a forced-release regrant of the same owner restarts at 1.
                if (lock_owner == win_id && burst_open) begin
                    burst_cnt_nxt = burst_cnt + 1'b1;
                end else begin
                    burst_cnt_nxt = CW'(1);
                end
            end else begin
                lock_owner_nxt = OWN_NONE;
                burst_cnt_nxt  = '0;
            end
        end else if ((lock_owner == OWN_H && !bus.h_req) ||
                     (lock_owner == OWN_E && !bus.e_req)) begin
            lock_owner_nxt = OWN_NONE;
            burst_cnt_nxt  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_owner  <= OWN_NONE;
            burst_cnt   <= '0;
            last_winner <= 1'b1;
        end else begin
            lock_owner  <= lock_owner_nxt;
            burst_cnt   <= burst_cnt_nxt;
            last_winner <= last_winner_nxt;
        end
    end

    // Read return pipe: {valid, id} per stage, id 1 = engine.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid <= '0;
            rd_id    <= '0;
            wdata_q  <= '0;
        end else begin
            rd_valid[0] <= any_gnt & ~win_write;
            rd_id[0]    <= gnt_e & ~win_write;
            for (int i = 1; i < READ_LATENCY; i++) begin
                rd_valid[i] <= rd_valid[i-1];
                rd_id[i]    <= rd_id[i-1];
            end
            wdata_q <= win_wdata;
        end
    end

    assign bus.h_gnt             = gnt_h;
    assign bus.e_gnt             = gnt_e;
    assign bus.h_readdatavalid   = rd_valid[READ_LATENCY-1] & ~rd_id[READ_LATENCY-1];
    assign bus.e_readdatavalid   = rd_valid[READ_LATENCY-1] &  rd_id[READ_LATENCY-1];
    assign bus.readdata          = bus.memory_readdata;
    assign bus.memory_address    = win_address;
    assign bus.memory_write      = win_write;
    assign bus.memory_writedata  = win_wdata;
    assign bus.memory_byteenable = win_be;
    assign bus.memory_chipselect = any_gnt;
    assign bus.memory_clken      = 1'b1;

`ifdef BLAST_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_grant_count  <= '0;
            e_grant_count  <= '0;
            conflict_count <= '0;
        end else if (stats_clear) begin
            h_grant_count  <= '0;
            e_grant_count  <= '0;
            conflict_count <= '0;
        end else begin
            if (gnt_h && h_grant_count != '1) begin
                h_grant_count <= h_grant_count + 1'b1;
            end
            if (gnt_e && e_grant_count != '1) begin
                e_grant_count <= e_grant_count + 1'b1;
            end
            if (bus.h_req && bus.e_req && conflict_count != '1) begin
                conflict_count <= conflict_count + 1'b1;
            end
        end
    end
`endif
endmodule

// File: doc/blast_mem_arbiter.md
Name: blast_mem_arbiter

Overview:
- Shares the single 64-bit on-chip memory port (14-bit word address) between two requesters: the host/PCIe-side app port (H) and the Blast engine port (E).
- E covers query reads, subject reads and hit-score writes. H loads query/subject blocks and reads back hit scores.
- Round-robin arbitration with burst locking. Read data returns tagged to the issuing requester after a fixed memory latency.
- Sits between the engine top and the Qsys on-chip memory slave.

Parameters:
- MEMORY_DATAWIDTH, 64, data width of memory and requester buses
- MEMORY_ADDRESS, 14, word address width
- READ_LATENCY, 1, cycles from accepted read to memory_readdata valid (1..4)
- MAX_BURST, 8, max consecutive locked grants before the lock is forcibly released

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- h_req  in  1  host request
- h_lock  in  1  host keeps grant across consecutive beats
- h_write  in  1  host write (1) / read (0)
- h_address  in  14  host word address
- h_writedata  in  64  host write data
- h_byteenable  in  8  host byte enables
- h_gnt  out  1  host beat accepted this cycle
- h_readdatavalid  out  1  host read data valid
- e_req / e_lock / e_write / e_address / e_writedata / e_byteenable  in  1/1/1/14/64/8  engine equivalents
- e_gnt  out  1  engine beat accepted this cycle
- e_readdatavalid  out  1  engine read data valid
- readdata  out  64  memory_readdata forwarded to both requesters
- memory_address  out  14  to memory
- memory_write  out  1  to memory
- memory_writedata  out  64  to memory
- memory_byteenable  out  8  to memory
- memory_chipselect  out  1  to memory
- memory_clken  out  1  tied 1
- memory_readdata  in  64  from memory

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low. All registers clear on its assertion and release synchronously to clk.
- Registers:
  - last_winner: 0 = H, 1 = E; reset value 1, so H wins the first tie.
  - lock_owner: none/H/E; reset value none.
  - burst_cnt: 0..MAX_BURST.
  - rd pipe: READ_LATENCY stages of {valid, id}.
- Grant logic is combinational from the current req/lock inputs and the registered state. A beat transfers in a cycle when req && gnt.
- Grant priority, evaluated each cycle:
  1. If lock_owner = X, X requests, and burst_cnt < MAX_BURST: grant X.
  2. Otherwise, if only one requester is active: grant it.
  3. Otherwise, if both are active: grant the one that is not last_winner.
  4. Otherwise: no grant.
- At most one gnt is high per cycle.
- On a granted beat by X:
  - last_winner <= X.
  - If lock_X = 1: lock_owner <= X. burst_cnt <= burst_cnt+1 if X already owned the lock, else 1.
  - If lock_X = 0: lock_owner <= none and burst_cnt <= 0.
- Forced lock release:
  - When burst_cnt = MAX_BURST and the other requester is active, the other requester wins that cycle. burst_cnt restarts from the new grant.
  - If the other requester is idle, the owner is granted and burst_cnt restarts at 1.
- If the lock owner drops req, lock_owner <= none in that same cycle.
- Memory outputs, combinational mux of the winner's signals:
  - memory_chipselect = any gnt; memory_write = winner write & gnt.
  - With no grant: address 0, write 0, writedata held at previous value, byteenable 0.
- Read return:
  - A granted read pushes {1, id} into the rd pipe.
  - The pipe output drives h_readdatavalid or e_readdatavalid, exactly READ_LATENCY cycles after the grant cycle. readdata = memory_readdata.
  - Writes push {0, x}.
  - Back-to-back reads from alternating requesters return in issue order, with no bubbles.
- Reset mid-burst: the lock and rd pipe clear. Pending readdatavalids are dropped; requesters must reissue.
- Write and read to the same address in consecutive cycles: memory ordering is preserved because beats are issued in grant order.

Optional Feature:
- Macro: BLAST_ARB_STATS_EN.
- When defined, adds outputs:
  - h_grant_count (32): granted host beats, saturating at 32'hFFFFFFFF.
  - e_grant_count (32): granted engine beats, saturating.
  - conflict_count (16): cycles with h_req && e_req, saturating.
  - stats_clear (in, 1): synchronous clear.
- All counters reset to 0.
- When undefined, these ports and registers do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, no requests -> memory_chipselect=0, memory_address=0, h_gnt=e_gnt=0, no readdatavalid.
- h_req read addr 14'h0005 alone, READ_LATENCY=1 -> h_gnt same cycle, memory_address=5; next cycle h_readdatavalid=1 with readdata=memory_readdata; e_readdatavalid stays 0.
- h_req and e_req held continuously, lock=0 both -> grants alternate H,E,H,E starting with H; memory_address alternates accordingly.
- e_lock=1 burst of 12 reads at addr 12..23, h_req asserted at the 3rd beat, MAX_BURST=8 -> E gets 8 consecutive grants (12..19); H granted next; E resumes at 20.
- E write 14'h3F7E with data 64'hFEDE_CAAD, then H read of the same addr on the next cycle -> memory_write=1 in the first cycle; H read issues one cycle later; h_readdatavalid after READ_LATENCY.
- reset_n pulsed low mid-locked-burst with 2 reads in flight (READ_LATENCY=3) -> outputs clear immediately; no readdatavalid fires after release; the next grant follows the round-robin reset value, H first.
